// File: rtl/mux_scan_sampler.sv
// Scans every mux channel by stepping the select, captures one bit per channel,
// and presents the captured word on a valid/ready output.
module mux_scan_sampler #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_in,
  output logic              busy,
  output logic [NUM_CH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] shadow;
  logic [NUM_CH-1:0] merged;

  // Shadow word with the bit for the current select replaced by the live mux output.
  always_comb begin
    merged = shadow;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (sel == SEL_W'(i)) merged[i] = mux_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cnt       <= '0;
      shadow    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SETTLE;
            sel   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          // Sample on the last settle cycle of this select value.
          if (cnt == CNT_LAST) begin
            shadow <= merged;
            cnt    <= '0;
            if (sel == LAST_SEL) begin
              out_data  <= merged;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              sel <= sel + SEL_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sel       <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
